fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction decoder. It holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched 32-bit command to decode over a valid/ready handshake. It then waits for the issued instruction to resolve and computes the next PC from the decoder's jSel/pcSel controls, the ALU zero flag, branch offset and jr register value. Non-pipelined: at most one instruction is in flight.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Non-pipelined instruction-fetch stage: one instruction in flight, req/ack to imem, valid/ready to decode.
// Optional performance counters (instr_count, stall_count) are compiled in when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] pc_out,
  input  logic        exec_valid,
  input  logic [1:0]  jSel,
  input  logic [1:0]  pcSel,
  input  logic        zero,
  input  logic [31:0] branchAddr,
  input  logic [31:0] jrAddr,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    HOLD     = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc4;
  logic        cmd_load, cmd_accept, resolve;

  assign imem_addr = pc;
  assign pc_out    = pc;
  // Request is a pure decode of the state, so an async reset drops it immediately.
  assign imem_req  = (state == REQ);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cmd_load   = 1'b0;
    cmd_accept = 1'b0;
    resolve    = 1'b0;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: if (imem_ack) begin
        state_next = HOLD;
        cmd_load   = 1'b1;
      end
      HOLD: if (cmd_valid && cmd_ready) begin
        state_next = WAIT_RES;
        cmd_accept = 1'b1;
      end
      WAIT_RES: if (exec_valid) begin
        state_next = REQ;
        resolve    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc4     = pc + 32'd4;
    pc_next = pc4;
    if (jSel == 2'd0) begin
      pc_next = {jrAddr[31:2], 2'b00};
    end else if (jSel == 2'd1) begin
      pc_next = {pc4[31:28], cmd[25:0], 2'b00};
    end else if ((pcSel == 2'd1 && zero) || (pcSel == 2'd2 && !zero)) begin
      pc_next = pc4 + (branchAddr << 2);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      cmd          <= 32'd0;
      cmd_valid    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_next;
      if (cmd_load) begin
        cmd       <= imem_rdata;
        cmd_valid <= 1'b1;
      end
      if (cmd_accept) cmd_valid <= 1'b0;
      if (resolve) begin
        pc <= pc_next;
        if (jSel == 2'd0 && jrAddr[1:0] != 2'b00) misalign_err <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (cmd_accept) instr_count <= instr_count + 32'd1;
      if ((state == REQ && !imem_ack) || (state == HOLD && !cmd_ready))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential flow, branches, jumps, jr misalignment,
// memory/decoder stalls, wrap-around and mid-request reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] pc_out;
  logic        exec_valid;
  logic [1:0]  jSel;
  logic [1:0]  pcSel;
  logic        zero;
  logic [31:0] branchAddr;
  logic [31:0] jrAddr;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] instr_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .pc_out       (pc_out),
    .exec_valid   (exec_valid),
    .jSel         (jSel),
    .pcSel        (pcSel),
    .zero         (zero),
    .branchAddr   (branchAddr),
    .jrAddr       (jrAddr),
    .misalign_err (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .instr_count  (instr_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full instruction: wait for the fetch, answer it, hand it to decode, then resolve it.
  task automatic fetch(input logic [31:0] exp_addr, input int ack_dly, input logic [31:0] word,
                       input int rdy_dly, input logic [1:0] js, input logic [1:0] ps,
                       input logic z, input logic [31:0] ba, input logic [31:0] ja,
                       output int waited);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, exp_addr);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("no_early_valid", {31'd0, cmd_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("cmd_valid_set", {31'd0, cmd_valid}, 32'd1);
    check("cmd", cmd, word);
    check("pc_out", pc_out, exp_addr);
    check("req_dropped", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, cmd_valid}, 32'd1);
      check("hold_cmd", cmd, word);
      check("hold_pc", pc_out, exp_addr);
      check("no_extra_req", {31'd0, imem_req}, 32'd0);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("cmd_valid_clr", {31'd0, cmd_valid}, 32'd0);
    check("pc_wait_stable", pc_out, exp_addr);
    exec_valid = 1'b1;
    jSel       = js;
    pcSel      = ps;
    zero       = z;
    branchAddr = ba;
    jrAddr     = ja;
    @(negedge clk);
    exec_valid = 1'b0;
    jSel       = 2'd2;
    pcSel      = 2'd0;
    zero       = 1'b0;
    branchAddr = 32'h0;
    jrAddr     = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    cmd_ready  = 1'b0;
    exec_valid = 1'b0;
    jSel       = 2'd2;
    pcSel      = 2'd0;
    zero       = 1'b0;
    branchAddr = 32'h0;
    jrAddr     = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc_out, 32'h0);
    check("rst_cmd", cmd, 32'h0);
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;

    // Sequential flow with zero-wait memory: back-to-back fetches every 3 cycles.
    fetch(32'h0000_0000, 0, 32'h1111_0000, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    fetch(32'h0000_0004, 0, 32'h1111_0004, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    check("loop_3cyc_a", w, 0);
    fetch(32'h0000_0008, 0, 32'h1111_0008, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    check("loop_3cyc_b", w, 0);
    fetch(32'h0000_000C, 0, 32'h1111_000C, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);

    // beq taken backwards: 0x14 - 8 = 0x0C; then beq not taken from 0x10 -> 0x14.
    fetch(32'h0000_0010, 0, 32'h1000_FFFE, 0, 2'd2, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, w);
    fetch(32'h0000_000C, 0, 32'h2222_000C, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    fetch(32'h0000_0010, 0, 32'h1000_FFFE, 0, 2'd2, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0, w);
    // beq taken from 0x14 back to 0x10, then bne taken: 0x14 + 12 = 0x20.
    fetch(32'h0000_0014, 0, 32'h1000_FFFE, 0, 2'd2, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, w);
    fetch(32'h0000_0010, 0, 32'h1400_0003, 0, 2'd2, 2'd2, 1'b0, 32'h0000_0003, 32'h0, w);
    // j with target field 0x40 -> 0x100.
    fetch(32'h0000_0020, 0, 32'h0800_0040, 0, 2'd1, 2'd0, 1'b0, 32'h0, 32'h0, w);
    // jr to a misaligned register value: low bits dropped, sticky error raised.
    fetch(32'h0000_0100, 0, 32'h0000_0008, 0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0000_0203, w);
    check("misalign_set", {31'd0, misalign_err}, 32'd1);
    // Slow memory (3 cycles) and busy decoder (2 cycles); sequential afterwards.
    fetch(32'h0000_0200, 3, 32'h3333_0200, 2, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    // pcSel=3 and jSel=3 both mean sequential even with zero=1.
    fetch(32'h0000_0204, 0, 32'h3333_0204, 0, 2'd3, 2'd3, 1'b1, 32'h0000_0010, 32'h0, w);
    // Aligned jr to the top word; bne with zero=1 not taken.
    fetch(32'h0000_0208, 0, 32'h0000_0008, 0, 2'd0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFFC, w);
    check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    fetch(32'hFFFF_FFFC, 0, 32'h1400_0005, 0, 2'd2, 2'd2, 1'b1, 32'h0000_0005, 32'h0, w);
    fetch(32'h0000_0000, 0, 32'h4444_0000, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    check("misalign_held", {31'd0, misalign_err}, 32'd1);

    // Reset while in REQ at pc=4 with the ack still outstanding.
    @(negedge clk);
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    check("pre_rst_addr", imem_addr, 32'h0000_0004);
    reset = 1'b1;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_valid", {31'd0, cmd_valid}, 32'd0);
    check("async_pc", pc_out, 32'h0);
    check("async_misalign", {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_PERF_EN
    check("async_icount", instr_count, 32'd0);
`endif
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("stale_ack_valid", {31'd0, cmd_valid}, 32'd0);
    check("stale_ack_cmd", cmd, 32'h0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0000_0000, 1, 32'h5555_0000, 0, 2'd2, 2'd0, 1'b0, 32'h0, 32'h0, w);
    check("restart_next", imem_addr, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
